// File: rtl/stack_pkg.sv
// stack_pkg: shared types for the frame_stack operand/call stack.
// Holds the request opcode, status and error codes and the frame record.
package stack_pkg;

   typedef enum logic [3:0] {
      OP_NOP         = 4'd0,
      OP_PUSH        = 4'd1,
      OP_POP         = 4'd2,
      OP_REPLACE     = 4'd3,
      OP_CALL        = 4'd4,
      OP_RETURN      = 4'd5,
      OP_LOCAL_GET   = 4'd6,
      OP_LOCAL_SET   = 4'd7,
      OP_INDEX_RESET = 4'd8
   } op_t;

   typedef enum logic [1:0] {
      ST_NONE      = 2'd0,
      ST_EMPTY     = 2'd1,
      ST_FULL      = 2'd2,
      ST_UNDERFLOW = 2'd3
   } status_t;

   typedef enum logic [2:0] {
      ERR_NONE            = 3'd0,
      ERR_UNDERFLOW       = 3'd1,
      ERR_OVERFLOW        = 3'd2,
      ERR_BAD_OFFSET      = 3'd3,
      ERR_FRAME_OVERFLOW  = 3'd4,
      ERR_FRAME_UNDERFLOW = 3'd5
   } err_t;

   // Record fields are wide enough for any DEPTH up to 6.
   localparam int REC_W = 8;

   typedef struct packed {
      logic [REC_W-1:0] base;
      logic [REC_W-1:0] limit;
   } frame_rec_t;

endpackage

// File: rtl/frame_stack_if.sv
// frame_stack_if: valid/ready request bundle into frame_stack.
// master drives req_valid/op/data/offset/count/drop_tos; slave drives req_ready.
interface frame_stack_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) ();
   import stack_pkg::*;

   logic             req_valid;
   logic             req_ready;
   op_t              op;
   logic [WIDTH-1:0] data;
   logic [DEPTH:0]   offset;
   logic [DEPTH:0]   count;
   logic             drop_tos;

   modport master (
      output req_valid, op, data, offset, count, drop_tos,
      input  req_ready
   );

   modport slave (
      input  req_valid, op, data, offset, count, drop_tos,
      output req_ready
   );

endinterface

// File: rtl/frame_record_stack.sv
// frame_record_stack: FRAMES-deep LIFO of {base, limit} call-frame records.
// Ports: clk, reset (sync, active-low), push/pop, push_rec, top_rec, level, full, empty.
module frame_record_stack
   import stack_pkg::*;
#(
   parameter int FRAME_DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  frame_rec_t           push_rec,
   output frame_rec_t           top_rec,
   output logic [FRAME_DEPTH:0] level,
   output logic                 full,
   output logic                 empty
);

   localparam int FRAMES = 2**FRAME_DEPTH;
   localparam int LW = FRAME_DEPTH + 1;

   frame_rec_t             recs [FRAMES];
   logic [LW-1:0]          lvl_q;
   logic [LW-1:0]          lvl_m1;
   logic [FRAME_DEPTH-1:0] top_ptr;

   assign full    = (lvl_q == LW'(FRAMES));
   assign empty   = (lvl_q == '0);
   assign lvl_m1  = lvl_q - LW'(1);
   assign top_ptr = lvl_m1[FRAME_DEPTH-1:0];
   assign top_rec = recs[top_ptr];
   assign level   = lvl_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         lvl_q <= '0;
      end else if (push && !full) begin
         lvl_q <= lvl_q + LW'(1);
      end else if (pop && !empty) begin
         lvl_q <= lvl_m1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && push && !full) begin
         recs[lvl_q[FRAME_DEPTH-1:0]] <= push_rec;
      end
   end

endmodule

// File: rtl/frame_stack.sv
// frame_stack: operand stack with hardware call frames, local get/set,
// multi-entry pop and multi-cycle RETURN result moving.
// Ports: clk, reset (sync, active-low), bus (request handshake, slave),
// index/frame_base/frame_limit/frame_level, out0..out2 (top three entries),
// getter/getter_valid, status, error (one-cycle pulse).
// Build option: FRAME_STACK_ZERO_FILL_EN makes CALL zero-fill its locals.
module frame_stack
   import stack_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int FRAME_DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   frame_stack_if.slave         bus,
   output logic [DEPTH:0]       index,
   output logic [DEPTH:0]       frame_base,
   output logic [DEPTH:0]       frame_limit,
   output logic [FRAME_DEPTH:0] frame_level,
   output logic [WIDTH-1:0]     out0,
   output logic [WIDTH-1:0]     out1,
   output logic [WIDTH-1:0]     out2,
   output logic [WIDTH-1:0]     getter,
   output logic                 getter_valid,
   output status_t              status,
   output err_t                 error
);

   localparam int ENTRIES = 2**DEPTH;
   // One spare bit so sums and differences never wrap into range.
   localparam int IW = DEPTH + 2;

   typedef logic [IW-1:0] idx_t;

   localparam idx_t ENT = idx_t'(ENTRIES);
   localparam idx_t ONE = idx_t'(1);

`ifdef FRAME_STACK_ZERO_FILL_EN
   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_ZERO} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_MOVE} state_t;
`endif

   logic [WIDTH-1:0] mem [ENTRIES];

   state_t           state_q, state_d;
   idx_t             idx_q, idx_d;
   idx_t             base_q, base_d;
   idx_t             lim_q, lim_d;
   idx_t             src_q, src_d;
   idx_t             dst_q, dst_d;
   idx_t             rem_q, rem_d;
   idx_t             end_q, end_d;
   err_t             err_q, err_d;
   logic [WIDTH-1:0] get_q, get_d;
   logic             gv_q, gv_d;

   logic             we;
   idx_t             waddr;
   logic [WIDTH-1:0] wdata;

   logic             f_push, f_pop, f_full, f_empty;
   frame_rec_t       push_rec, top_rec;
   logic             unused_rec;

   idx_t             off, cnt, loc, tos, a1, a2, ret_src;
   logic             acc;

   assign off     = idx_t'(bus.offset);
   assign cnt     = idx_t'(bus.count);
   assign loc     = base_q + off;
   assign tos     = idx_q - ONE;
   assign a1      = idx_q - idx_t'(2);
   assign a2      = idx_q - idx_t'(3);
   assign ret_src = idx_q - cnt;

   assign bus.req_ready = (state_q == S_IDLE);
   assign acc = bus.req_valid && bus.req_ready;

   assign push_rec = '{base: REC_W'(base_q), limit: REC_W'(lim_q)};
   assign unused_rec = ^top_rec;

   frame_record_stack #(
      .FRAME_DEPTH(FRAME_DEPTH)
   ) u_frames (
      .clk      (clk),
      .reset    (reset),
      .push     (f_push),
      .pop      (f_pop),
      .push_rec (push_rec),
      .top_rec  (top_rec),
      .level    (frame_level),
      .full     (f_full),
      .empty    (f_empty)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      base_d  = base_q;
      lim_d   = lim_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      end_d   = end_q;
      err_d   = ERR_NONE;
      get_d   = get_q;
      gv_d    = 1'b0;
      we      = 1'b0;
      waddr   = idx_q;
      wdata   = '0;
      f_push  = 1'b0;
      f_pop   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (acc) begin
               unique case (bus.op)
                  OP_PUSH: begin
                     if (idx_q >= ENT) begin
                        err_d = ERR_OVERFLOW;
                     end else begin
                        we    = 1'b1;
                        waddr = idx_q;
                        wdata = bus.data;
                        idx_d = idx_q + ONE;
                     end
                  end
                  OP_POP: begin
                     if (cnt != '0) begin
                        if (idx_q < lim_q + cnt) err_d = ERR_UNDERFLOW;
                        else                     idx_d = ret_src;
                     end
                  end
                  OP_REPLACE: begin
                     if (idx_q <= lim_q) begin
                        err_d = ERR_UNDERFLOW;
                     end else begin
                        we    = 1'b1;
                        waddr = tos;
                        wdata = bus.data;
                     end
                  end
                  OP_CALL: begin
                     if (lim_q + off > idx_q) begin
                        err_d = ERR_UNDERFLOW;
                     end else if (idx_q + cnt > ENT) begin
                        err_d = ERR_OVERFLOW;
                     end else if (f_full) begin
                        err_d = ERR_FRAME_OVERFLOW;
                     end else begin
                        f_push = 1'b1;
                        base_d = idx_q - off;
                        lim_d  = idx_q + cnt;
                        idx_d  = idx_q + cnt;
`ifdef FRAME_STACK_ZERO_FILL_EN
                        // index walks up to the new limit while filling.
                        if (cnt != '0) begin
                           idx_d   = idx_q;
                           rem_d   = cnt;
                           state_d = S_ZERO;
                        end
`endif
                     end
                  end
                  OP_RETURN: begin
                     if (f_empty) begin
                        err_d = ERR_FRAME_UNDERFLOW;
                     end else if (lim_q + cnt > idx_q) begin
                        err_d = ERR_UNDERFLOW;
                     end else if (cnt > ONE && ret_src != base_q) begin
                        state_d = S_MOVE;
                        src_d   = ret_src;
                        dst_d   = base_q;
                        rem_d   = cnt;
                        end_d   = base_q + cnt;
                     end else begin
                        if (cnt == ONE) begin
                           we    = 1'b1;
                           waddr = base_q;
                           wdata = mem[ret_src[DEPTH-1:0]];
                        end
                        idx_d  = base_q + cnt;
                        f_pop  = 1'b1;
                        base_d = idx_t'(top_rec.base);
                        lim_d  = idx_t'(top_rec.limit);
                     end
                  end
                  OP_LOCAL_GET: begin
                     if (loc >= lim_q) begin
                        err_d = ERR_BAD_OFFSET;
                     end else begin
                        get_d = mem[loc[DEPTH-1:0]];
                        gv_d  = 1'b1;
                     end
                  end
                  OP_LOCAL_SET: begin
                     if (loc >= lim_q) begin
                        err_d = ERR_BAD_OFFSET;
                     end else if (bus.drop_tos) begin
                        if (idx_q <= lim_q) begin
                           err_d = ERR_UNDERFLOW;
                        end else begin
                           we    = 1'b1;
                           waddr = loc;
                           wdata = mem[tos[DEPTH-1:0]];
                           idx_d = tos;
                        end
                     end else begin
                        we    = 1'b1;
                        waddr = loc;
                        wdata = bus.data;
                     end
                  end
                  OP_INDEX_RESET: idx_d = off;
                  default: ;
               endcase
            end
         end
         S_MOVE: begin
            we    = 1'b1;
            waddr = dst_q;
            wdata = mem[src_q[DEPTH-1:0]];
            src_d = src_q + ONE;
            dst_d = dst_q + ONE;
            rem_d = rem_q - ONE;
            if (rem_q == ONE) begin
               state_d = S_IDLE;
               idx_d   = end_q;
               f_pop   = 1'b1;
               base_d  = idx_t'(top_rec.base);
               lim_d   = idx_t'(top_rec.limit);
            end
         end
`ifdef FRAME_STACK_ZERO_FILL_EN
         S_ZERO: begin
            we    = 1'b1;
            waddr = idx_q;
            wdata = '0;
            idx_d = idx_q + ONE;
            rem_d = rem_q - ONE;
            if (rem_q == ONE) state_d = S_IDLE;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         base_q  <= '0;
         lim_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         end_q   <= '0;
         err_q   <= ERR_NONE;
         get_q   <= '0;
         gv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         lim_q   <= lim_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         end_q   <= end_d;
         err_q   <= err_d;
         get_q   <= get_d;
         gv_q    <= gv_d;
      end
   end

   // Memory is never cleared; writes are suppressed while in reset.
   always_ff @(posedge clk) begin
      if (reset && we) mem[waddr[DEPTH-1:0]] <= wdata;
   end

   always_comb begin
      status = ST_NONE;
      if (idx_q == ENT)       status = ST_FULL;
      else if (idx_q == lim_q) status = ST_EMPTY;
      else if (idx_q < lim_q)  status = ST_UNDERFLOW;
   end

   assign out0 = (idx_q > idx_t'(0)) ? mem[tos[DEPTH-1:0]] : '0;
   assign out1 = (idx_q > idx_t'(1)) ? mem[a1[DEPTH-1:0]] : '0;
   assign out2 = (idx_q > idx_t'(2)) ? mem[a2[DEPTH-1:0]] : '0;

   assign index        = idx_q[DEPTH:0];
   assign frame_base   = base_q[DEPTH:0];
   assign frame_limit  = lim_q[DEPTH:0];
   assign getter       = get_q;
   assign getter_valid = gv_q;
   assign error        = err_q;

endmodule
